// File: rtl/otter_ctrl_pkg.sv
// Shared types and constants for the Otter pipeline flow controller.
package otter_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SQUASH = 2'd1,
    FREEZE = 2'd2
  } flow_state_t;

  localparam logic [2:0] PC_SEQ    = 3'd0;
  localparam logic [2:0] PC_JALR   = 3'd1;
  localparam logic [2:0] PC_BRANCH = 3'd2;
  localparam logic [2:0] PC_JAL    = 3'd3;

  // Only RUN and SQUASH are meaningful as a remembered pre-freeze state.
  function automatic logic is_squash(input flow_state_t s);
    return (s == SQUASH);
  endfunction

endpackage

// File: rtl/otter_perf_cnt.sv
// Free-running wrapping event counter with synchronous clear.
module otter_perf_cnt
  import otter_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear beats a same-cycle increment; the add wraps naturally.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/otter_flow_ctrl.sv
// Pipeline flow controller: PC select, stage enables, flushes, squash flag
// and redirect/stall performance counters for the pipelined Otter core.
module otter_flow_ctrl
  import otter_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [2:0]       pc_source_EX,
  input  logic             ld_use_ID,
  input  logic             mem_busy,
  input  logic             cnt_clr,
  output logic [2:0]       pc_sel,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic             squash_EX,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  flow_state_t state_q, state_d;
  flow_state_t saved_q, saved_d;
  flow_state_t eff_state;
  logic        squash_q, squash_d;
  logic        redirect_ok;

  // When frozen, the cycle in which mem_busy drops already behaves as the
  // remembered state, so a held-off redirect is taken with no extra delay.
  always_comb begin
    eff_state   = (state_q == FREEZE) ? saved_q : state_q;
    redirect_ok = !RST && !mem_busy && (eff_state == RUN) &&
                  (pc_source_EX != PC_SEQ);
  end

  always_comb begin
    state_d     = state_q;
    saved_d     = saved_q;
    pc_sel      = PC_SEQ;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    id_ex_write = 1'b1;
    flush_IF_ID = 1'b0;
    flush_ID_EX = 1'b0;

    if (RST) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
      flush_IF_ID = 1'b1;
      flush_ID_EX = 1'b1;
      state_d     = RUN;
      saved_d     = RUN;
    end else if (mem_busy) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
      state_d     = FREEZE;
      saved_d     = eff_state;
    end else if (redirect_ok) begin
      pc_sel      = pc_source_EX;
      flush_IF_ID = 1'b1;
      flush_ID_EX = 1'b1;
      state_d     = SQUASH;
    end else begin
      if (ld_use_ID) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        flush_ID_EX = 1'b1;
      end
      state_d = RUN;
    end
  end

  // The squash flag tracks the EX slot, which freezing leaves untouched.
  always_comb begin
    squash_d = is_squash(state_d) ||
               ((state_d == FREEZE) && is_squash(saved_d));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= RUN;
      saved_q  <= RUN;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      saved_q  <= saved_d;
      squash_q <= squash_d;
    end
  end

  assign squash_EX = squash_q;

  otter_perf_cnt #(.CNT_W(CNT_W)) u_redirect_cnt (
    .clk   (CLK),
    .rst   (RST),
    .clr   (cnt_clr),
    .inc   (redirect_ok),
    .count (redirect_cnt)
  );

  otter_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (CLK),
    .rst   (RST),
    .clr   (cnt_clr),
    .inc   (!RST && !pc_write),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_otter_flow_ctrl.sv
// Directed self-checking bench for otter_flow_ctrl, built with 4-bit counters.
module tb_otter_flow_ctrl;

  localparam int CNT_W = 4;

  logic             CLK;
  logic             RST;
  logic [2:0]       pc_source_EX;
  logic             ld_use_ID;
  logic             mem_busy;
  logic             cnt_clr;
  logic [2:0]       pc_sel;
  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_write;
  logic             flush_IF_ID;
  logic             flush_ID_EX;
  logic             squash_EX;
  logic [CNT_W-1:0] redirect_cnt;
  logic [CNT_W-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  otter_flow_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .pc_source_EX (pc_source_EX),
    .ld_use_ID    (ld_use_ID),
    .mem_busy     (mem_busy),
    .cnt_clr      (cnt_clr),
    .pc_sel       (pc_sel),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .id_ex_write  (id_ex_write),
    .flush_IF_ID  (flush_IF_ID),
    .flush_ID_EX  (flush_ID_EX),
    .squash_EX    (squash_EX),
    .redirect_cnt (redirect_cnt),
    .stall_cnt    (stall_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Inputs change just after the falling edge; outputs are sampled 1 ns later.
  task automatic applyStimulus(input logic rst, input logic [2:0] src,
                               input logic lu, input logic busy,
                               input logic clr);
    RST          = rst;
    pc_source_EX = src;
    ld_use_ID    = lu;
    mem_busy     = busy;
    cnt_clr      = clr;
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed,
                             input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  initial begin
    applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();

    // Reset held two cycles with a branch on the input
    applyStimulus(1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_pc_write", pc_write, 0);
    checkOutput("rst_if_id_write", if_id_write, 0);
    checkOutput("rst_id_ex_write", id_ex_write, 0);
    checkOutput("rst_flush_if_id", flush_IF_ID, 1);
    checkOutput("rst_flush_id_ex", flush_ID_EX, 1);
    checkOutput("rst_pc_sel", pc_sel, 0);
    tick();
    applyStimulus(1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    checkOutput("rst2_pc_write", pc_write, 0);
    tick();
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_squash", squash_EX, 0);
    checkOutput("post_rst_redirect_cnt", redirect_cnt, 0);
    checkOutput("post_rst_stall_cnt", stall_cnt, 0);
    checkOutput("idle_pc_write", pc_write, 1);
    checkOutput("idle_flush_id_ex", flush_ID_EX, 0);
    tick();

    // Taken branch, then masked JAL in the squash cycle
    applyStimulus(1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
    checkOutput("br_pc_sel", pc_sel, 2);
    checkOutput("br_flush_if_id", flush_IF_ID, 1);
    checkOutput("br_flush_id_ex", flush_ID_EX, 1);
    checkOutput("br_pc_write", pc_write, 1);
    tick();
    applyStimulus(1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
    checkOutput("sq_squash", squash_EX, 1);
    checkOutput("sq_pc_sel_masked", pc_sel, 0);
    checkOutput("sq_flush_if_id", flush_IF_ID, 0);
    checkOutput("sq_redirect_cnt", redirect_cnt, 1);
    tick();

    // Load-use for two cycles
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("lu_squash_cleared", squash_EX, 0);
    checkOutput("lu1_pc_write", pc_write, 0);
    checkOutput("lu1_if_id_write", if_id_write, 0);
    checkOutput("lu1_id_ex_write", id_ex_write, 1);
    checkOutput("lu1_flush_id_ex", flush_ID_EX, 1);
    checkOutput("lu1_flush_if_id", flush_IF_ID, 0);
    tick();
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("lu2_pc_write", pc_write, 0);
    checkOutput("lu2_flush_id_ex", flush_ID_EX, 1);
    tick();
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_stall_cnt", stall_cnt, 2);
    checkOutput("lu_done_pc_write", pc_write, 1);
    tick();

    // JALR together with load-use: redirect wins
    applyStimulus(1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
    checkOutput("rlu_pc_write", pc_write, 1);
    checkOutput("rlu_pc_sel", pc_sel, 1);
    checkOutput("rlu_flush_if_id", flush_IF_ID, 1);
    checkOutput("rlu_flush_id_ex", flush_ID_EX, 1);
    tick();

    // Freeze entered from SQUASH, JAL arriving mid-freeze
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("rlu_stall_unchanged", stall_cnt, 2);
    checkOutput("rlu_redirect_cnt", redirect_cnt, 2);
    checkOutput("fz1_squash", squash_EX, 1);
    checkOutput("fz1_pc_write", pc_write, 0);
    checkOutput("fz1_id_ex_write", id_ex_write, 0);
    checkOutput("fz1_flush_id_ex", flush_ID_EX, 0);
    tick();
    applyStimulus(1'b0, 3'd3, 1'b0, 1'b1, 1'b0);
    checkOutput("fz2_squash", squash_EX, 1);
    checkOutput("fz2_pc_sel", pc_sel, 0);
    tick();
    applyStimulus(1'b0, 3'd3, 1'b0, 1'b1, 1'b0);
    checkOutput("fz3_squash", squash_EX, 1);
    tick();
    applyStimulus(1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
    checkOutput("rel_squash", squash_EX, 1);
    checkOutput("rel_pc_sel_masked", pc_sel, 0);
    checkOutput("rel_pc_write", pc_write, 1);
    checkOutput("fz_stall_cnt", stall_cnt, 5);
    tick();
    applyStimulus(1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
    checkOutput("jal_squash", squash_EX, 0);
    checkOutput("jal_pc_sel", pc_sel, 3);
    checkOutput("jal_flush_if_id", flush_IF_ID, 1);
    checkOutput("jal_redirect_cnt_before", redirect_cnt, 2);
    tick();
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("jal_squash_next", squash_EX, 1);
    checkOutput("jal_redirect_cnt_after", redirect_cnt, 3);
    tick();

    // Branch held off by mem_busy, taken when busy drops
    applyStimulus(1'b0, 3'd2, 1'b0, 1'b1, 1'b0);
    checkOutput("hold_pc_sel", pc_sel, 0);
    checkOutput("hold_flush_if_id", flush_IF_ID, 0);
    tick();
    applyStimulus(1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
    checkOutput("hold_squash", squash_EX, 0);
    checkOutput("hold_release_pc_sel", pc_sel, 2);
    checkOutput("hold_stall_cnt", stall_cnt, 6);
    tick();
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("hold_squash_after", squash_EX, 1);
    checkOutput("hold_redirect_cnt", redirect_cnt, 4);
    tick();

    // Clear in a stall cycle, then wrap the 4-bit stall counter
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("clr_stall_cnt", stall_cnt, 0);
    checkOutput("clr_redirect_cnt", redirect_cnt, 0);
    tick();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("wrap_stall_cnt", stall_cnt, 1);
    tick();

    // Reset asserted mid-squash
    applyStimulus(1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_sq_squash_before", squash_EX, 1);
    checkOutput("rst_sq_pc_write", pc_write, 0);
    tick();
    applyStimulus(1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_sq_squash_after", squash_EX, 0);
    checkOutput("rst_sq_redirect_cnt", redirect_cnt, 0);
    checkOutput("rst_sq_stall_cnt", stall_cnt, 0);
    checkOutput("rst_sq_run_pc_sel", pc_sel, 2);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
